// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: requester command/response ports plus the AXI read channels of the shared master port
interface axi_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int M_AXI_ID_WIDTH = 4,
  parameter int M_AXI_DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [9*NUM_REQ-1:0] req_len;
  logic [M_AXI_DATA_WIDTH-1:0] rsp_data, m_axi_rdata;
  logic [1:0] rsp_resp, m_axi_rresp, m_axi_arburst;
  logic rsp_last, busy, err;
  logic [31:0] m_axi_araddr;
  logic [M_AXI_ID_WIDTH-1:0] m_axi_arid, m_axi_rid;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic m_axi_arvalid, m_axi_arready, m_axi_rready, m_axi_rvalid, m_axi_rlast;
  modport master (
    input  req_valid, req_addr, req_len, rsp_ready,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rid, m_axi_rlast,
    output req_ready, rsp_valid, rsp_data, rsp_resp, rsp_last, busy, err,
           m_axi_araddr, m_axi_arvalid, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready
  );
  modport slave (
    output req_valid, req_addr, req_len, rsp_ready,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rid, m_axi_rlast,
    input  req_ready, rsp_valid, rsp_data, rsp_resp, rsp_last, busy, err,
           m_axi_araddr, m_axi_arvalid, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI read port among NUM_REQ burst requesters
module axi_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int M_AXI_ID_WIDTH = 4,
  parameter int M_AXI_DATA_WIDTH = 32
) (
  input logic m_axi_aclk,
  input logic m_axi_aresetn,
  axi_rd_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, g, gnt_idx, j, g_inc;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [31:0] addr;
  logic [8:0] len, cnt, cmd_len;
  logic gnt_any, xfer, beat, sel, err_q;
  assign sel = state == IDLE && req_ready_q == '0 && gnt_any;
  assign xfer = |(req_ready_q & bus.req_valid);
  assign beat = state == DATA && bus.m_axi_rvalid && bus.m_axi_rready;
  assign g_inc = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  assign cmd_len = (bus.req_len[9*g +: 9] > 9'd256) ? 9'd256 : bus.req_len[9*g +: 9];
  // lowest k wins, so the scan effectively starts at rr_ptr and wraps
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = j;
      end
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && xfer && cmd_len != 9'd0) ? ADDR :
               (state == ADDR && bus.m_axi_arready) ? DATA :
               (beat && bus.m_axi_rlast) ? IDLE : state;
  end
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn)
    if (!m_axi_aresetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      rr_ptr <= '0;
      g <= '0;
      req_ready_q <= '0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      req_ready_q <= sel ? NUM_REQ'(1) << gnt_idx : '0;
      if (sel) g <= gnt_idx;
      if (xfer) begin
        addr <= bus.req_addr[32*g +: 32];
        len <= cmd_len;
      end
      if (xfer && cmd_len == 9'd0) rr_ptr <= g_inc;
      if (beat && bus.m_axi_rlast) rr_ptr <= g_inc;
      cnt <= (state == ADDR) ? '0 : beat ? cnt + 9'd1 : cnt;
      err_q <= beat && (bus.m_axi_rid != M_AXI_ID_WIDTH'(g) || bus.m_axi_rlast != (cnt + 9'd1 == len));
    end
  end
  assign bus.req_ready = req_ready_q;
  assign bus.m_axi_arvalid = state == ADDR;
  assign bus.m_axi_araddr = (state == ADDR) ? addr : '0;
  assign bus.m_axi_arid = (state == ADDR) ? M_AXI_ID_WIDTH'(g) : '0;
  assign bus.m_axi_arlen = (state == ADDR) ? 8'(len - 9'd1) : '0;
  assign bus.m_axi_arsize = 3'($clog2(M_AXI_DATA_WIDTH / 8));
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_rready = state == DATA && bus.rsp_ready[g];
  assign bus.rsp_valid = (state == DATA && bus.m_axi_rvalid) ? NUM_REQ'(1) << g : '0;
  assign bus.rsp_data = bus.m_axi_rdata;
  assign bus.rsp_resp = bus.m_axi_rresp;
  assign bus.rsp_last = bus.m_axi_rlast;
  assign bus.busy = state != IDLE;
  assign bus.err = err_q;
endmodule
